// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: IDLE -> FETCH -> LOAD -> EXEC loop with HALT/FAULT sinks.
// Every output is decoded from registered state, so no input reaches an output combinationally.
module fetch_controller #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    TIMEOUT     = 8,
    parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   ir_load,
    output logic [INSTR_WIDTH-1:0] ir_wdata,
    output logic                   exec_start,
    input  logic                   exec_done,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [2:0]             state,
    output logic                   halted,
    output logic                   fault
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   exec_first_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            cnt_q        <= '0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            cnt_q        <= cnt_d;
            // Marks the first EXEC cycle so exec_start is a single pulse.
            exec_first_q <= (state_q == S_LOAD) && (state_d == S_EXEC);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                // Ready in the last allowed cycle still counts as a successful fetch.
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1))
                        state_d = S_FAULT;
                end
            end
            S_LOAD: begin
                if (ir_q[INSTR_WIDTH-1 -: 4] == HALT_OPCODE)
                    state_d = S_HALT;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    pc_d    = branch_taken ? branch_target : pc_q + ADDR_WIDTH'(1);
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign ir_load    = (state_q == S_LOAD);
    assign ir_wdata   = ir_q;
    assign exec_start = exec_first_q;
    assign pc         = pc_q;
    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: vector table of instructions plus directed halt/timeout/reset sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fetch_controller;
    logic        clk, reset, start;
    logic        imem_req, imem_ready;
    logic [15:0] imem_addr, imem_rdata;
    logic        ir_load, exec_start, exec_done, branch_taken;
    logic [15:0] ir_wdata, branch_target, pc;
    logic [2:0]  state;
    logic        halted, fault;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [15:0] data;
        int          waits;
        int          dly;
        bit          taken;
        logic [15:0] tgt;
        logic [15:0] pc_before;
        logic [15:0] pc_after;
    } vec_t;
    vec_t vecs[6];

    fetch_controller dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ir_load(ir_load), .ir_wdata(ir_wdata), .exec_start(exec_start), .exec_done(exec_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .state(state), .halted(halted), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state"}, 32'(state), 32'd0);
        check({tag, " pc"}, 32'(pc), 32'h0);
        check({tag, " ir_wdata"}, 32'(ir_wdata), 32'h0);
        check({tag, " ctl"}, {27'b0, imem_req, ir_load, exec_start, halted, fault}, 32'h0);
    endtask

    // Entered at a falling edge with the DUT in FETCH; leaves at a falling edge in FETCH/HALT.
    task automatic do_instr(input vec_t v);
        logic [15:0] exp_ir;
        check("fetch req", 32'(imem_req), 32'd1);
        check("fetch addr", 32'(imem_addr), 32'(v.pc_before));
        for (int i = 0; i < v.waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = 16'hDEAD;
            @(negedge clk);
            check("wait state", 32'(state), 32'd1);
            check("wait fault", 32'(fault), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = v.data;
        sb.push_back(v.data);
        @(negedge clk);
        // Ready outside FETCH must not recapture.
        imem_rdata = 16'hBEEF;
        check("load strobe", 32'(ir_load), 32'd1);
        check("load state", 32'(state), 32'd2);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            exp_ir = sb.pop_front();
            check("ir_wdata", 32'(ir_wdata), 32'(exp_ir));
        end
        @(negedge clk);
        imem_ready = 1'b0;
        if (v.data[15:12] == 4'hF) begin
            check("halt state", 32'(state), 32'd4);
            check("halted", 32'(halted), 32'd1);
            check("halt no exec_start", 32'(exec_start), 32'd0);
            check("halt pc", 32'(pc), 32'(v.pc_before));
            return;
        end
        check("exec state", 32'(state), 32'd3);
        check("exec_start", 32'(exec_start), 32'd1);
        check("ir held", 32'(ir_wdata), 32'(v.data));
        for (int i = 0; i < v.dly; i++) begin
            @(negedge clk);
            check("exec_start once", 32'(exec_start), 32'd0);
            check("exec wait state", 32'(state), 32'd3);
        end
        exec_done     = 1'b1;
        branch_taken  = v.taken;
        branch_target = v.tgt;
        @(negedge clk);
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        check("next state", 32'(state), 32'd1);
        check("next pc", 32'(pc), 32'(v.pc_after));
        check("next addr", 32'(imem_addr), 32'(v.pc_after));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; start = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; branch_taken = 1'b0; branch_target = '0;
        vecs[0] = '{16'h1234, 0, 0, 1'b0, 16'h0000, 16'h0000, 16'h0001};
        vecs[1] = '{16'h5678, 3, 1, 1'b1, 16'h0040, 16'h0001, 16'h0040};
        vecs[2] = '{16'h0ABC, 7, 2, 1'b0, 16'h1111, 16'h0040, 16'h0041};
        vecs[3] = '{16'h1111, 0, 0, 1'b1, 16'hFFFF, 16'h0041, 16'hFFFF};
        vecs[4] = '{16'h2222, 1, 0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[5] = '{16'hF000, 2, 0, 1'b0, 16'h0000, 16'h0000, 16'h0000};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle hold", 32'(state), 32'd0);
        pulse_start();
        for (int i = 0; i < 6; i++) do_instr(vecs[i]);

        // HALT is sticky against every input.
        start = 1'b1; imem_ready = 1'b1; exec_done = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0; imem_ready = 1'b0; exec_done = 1'b0;
        check("halt sticky state", 32'(state), 32'd4);
        check("halt sticky pc", 32'(pc), 32'h0);
        check("halt no req", 32'(imem_req), 32'd0);

        // Timeout into FAULT.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            check("timeout fetch", 32'(state), 32'd1);
            @(negedge clk);
        end
        check("fault state", 32'(state), 32'd5);
        check("fault flag", 32'(fault), 32'd1);
        check("fault no req", 32'(imem_req), 32'd0);
        start = 1'b1; imem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; imem_ready = 1'b0;
        check("fault sticky", 32'(state), 32'd5);
        #2 reset = 1'b1;
        #1 check_reset_outputs("fault reset");
        @(negedge clk);
        reset = 1'b0;

        // Branch to 5, then reset in the middle of the next EXEC.
        pulse_start();
        v = '{16'h0777, 0, 0, 1'b1, 16'h0005, 16'h0000, 16'h0005};
        do_instr(v);
        imem_ready = 1'b1; imem_rdata = 16'h3333;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        check("pre-reset exec", 32'(exec_start), 32'd1);
        check("pre-reset pc", 32'(pc), 32'h5);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid exec reset");
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        check("refetch req", 32'(imem_req), 32'd1);
        check("refetch addr", 32'(imem_addr), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
